seq_adder_flags: RTL

Parametrised, multi-cycle add/subtract unit that produces the full status flag set: sign, zero, carry, parity and overflow. Each cycle it processes CHUNK bits of a WIDTH-bit operand pair through a single CHUNK-bit adder slice, so area scales with CHUNK rather than WIDTH. Operands arrive on a valid/ready input handshake and results leave on a valid/ready output handshake. The block is the datapath-side arithmetic unit for the ALU and address-generation paths.

---
 rtl/adder_pkg.sv | 34 +++
 rtl/chunk_adder.sv | 27 ++
 rtl/seq_adder_flags.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the sequential add/subtract unit.
//   state_t         : operation FSM encoding (IDLE, BUSY, DONE)
//   nchunk()        : cycles per operation for a given WIDTH/CHUNK
//   idx_width()     : chunk-index counter width, clog2(NCHUNK) with a floor of 1
//   NCHUNK / IDX_W  : values for the default 16/4 configuration
//   cfg_ok()        : legal-configuration test used by the elaboration check
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;
  localparam int NCHUNK    = nchunk(WIDTH_DEF, CHUNK_DEF);
  localparam int IDX_W     = idx_width(NCHUNK);

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder
// Combinational CHUNK-bit adder slice, reused every cycle by seq_adder_flags.
//   a, b   : slice operands
//   cin    : carry into bit 0
//   s      : slice sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (feeds the overflow flag on the last slice)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out by XOR.
  assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/seq_adder_flags.sv
// seq_adder_flags
// Multi-cycle WIDTH-bit add/subtract unit with sign, zero, carry, parity and
// overflow flags. One CHUNK-bit slice is added per cycle, so an operation takes
// NCHUNK = WIDTH/CHUNK cycles in BUSY.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = state IDLE)
//   x, y, sub           : operands; sub=1 computes x + ~y + 1
//   out_valid/out_ready : result handshake (out_valid = state DONE)
//   z                   : result, modulo 2^WIDTH
//   sign, zero, carry, parity, overflow : status of z (carry=1 means no borrow on sub)
module seq_adder_flags
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int               NCHUNK_L = nchunk(WIDTH, CHUNK);
  localparam int               IDX_W_L  = idx_width(NCHUNK_L);
  localparam logic [IDX_W_L-1:0] LAST_IDX = IDX_W_L'(NCHUNK_L - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("seq_adder_flags: WIDTH must be a positive multiple of CHUNK");
  end

  state_t               state, state_nxt;
  logic [IDX_W_L-1:0]   idx;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [WIDTH-1:0]     z_r, z_nxt;
  logic                 cy_r;
  logic                 zacc_r;
  logic                 sign_r, zero_r, carry_r, parity_r, ovf_r;
  logic [CHUNK-1:0]     a_sl, b_sl, s_sl;
  logic                 cout, c_msb;
  logic                 accept, last;

  // Handshake outputs are pure state decodes.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (idx == LAST_IDX);

  assign a_sl = a_r[idx*CHUNK +: CHUNK];
  assign b_sl = b_r[idx*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (cy_r),
    .s     (s_sl),
    .cout  (cout),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Result word with the current slice merged in; on the last slice this is
  // the final z, which the flags are taken from.
  always_comb begin
    z_nxt = z_r;
    z_nxt[idx*CHUNK +: CHUNK] = s_sl;
  end

  // Operand capture: subtraction is folded in as an inverted y plus carry-in 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= x;
      b_r <= sub ? ~y : y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      cy_r     <= 1'b0;
      zacc_r   <= 1'b0;
      z_r      <= '0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      parity_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      cy_r   <= sub;
      zacc_r <= 1'b1;
    end else if (state == BUSY) begin
      z_r    <= z_nxt;
      cy_r   <= cout;
      zacc_r <= zacc_r & ~|s_sl;
      idx    <= idx + IDX_W_L'(1);
      if (last) begin
        idx      <= '0;
        sign_r   <= z_nxt[WIDTH-1];
        parity_r <= ~^z_nxt;
        zero_r   <= zacc_r & ~|s_sl;
        carry_r  <= cout;
        ovf_r    <= c_msb ^ cout;
      end
    end
  end

  assign z        = z_r;
  assign sign     = sign_r;
  assign zero     = zero_r;
  assign carry    = carry_r;
  assign parity   = parity_r;
  assign overflow = ovf_r;

endmodule
